// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for an N-digit multiplexed seven-segment display. It walks the digits
// with a dark gap before each one, and new values are committed only on frame boundaries.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    lz_en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_in_i,
    output logic [3:0]              digit_nibble_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic                    frame_done_o,
    output logic                    load_pending_o
);

    localparam int VAL_W   = 4 * NUM_DIGITS;
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VAL_W-1:0]  shown_q, shown_d;
    logic [VAL_W-1:0]  pending_q, pending_d;
    logic              lp_q, lp_d;

    logic              boundary;
    logic [VAL_W-1:0]  upper;
    logic              suppress;
    logic [NUM_DIGITS-1:0] onehot;

    // upper holds the current digit and everything above it; empty means a leading zero
    always_comb begin
        upper    = shown_q >> {idx_q, 2'b00};
        boundary = (state_q == ST_SHOW) && (idx_q == IDX_LAST) && (cnt_q == DWELL_LAST);
        suppress = lz_en_i && (idx_q != '0) && (upper == '0);
        onehot   = '0;
        onehot[idx_q] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shown_d   = shown_q;
        pending_d = pending_q;
        lp_d      = lp_q;

        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    shown_d = value_in_i;
                    lp_d    = 1'b0;
                end
                if (enable_i) begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load landing on the boundary edge goes straight to shown and beats pending
        if (state_q != ST_IDLE) begin
            if (boundary && enable_i) begin
                if (load_i) begin
                    shown_d = value_in_i;
                    lp_d    = 1'b0;
                end else if (lp_q) begin
                    shown_d = pending_q;
                    lp_d    = 1'b0;
                end
            end else if (load_i) begin
                pending_d = value_in_i;
                lp_d      = 1'b1;
            end
            if (!enable_i) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            shown_q   <= '0;
            pending_q <= '0;
            lp_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shown_q   <= shown_d;
            pending_q <= pending_d;
            lp_q      <= lp_d;
        end
    end

    assign digit_nibble_o = (state_q == ST_IDLE) ? 4'h0 : upper[3:0];
    assign digit_en_o     = (state_q == ST_SHOW && !suppress) ? onehot : '0;
    assign frame_done_o   = boundary;
    assign load_pending_o = lp_q;

endmodule
